// File: rtl/vga_scan_timing.sv
// VGA scan timing: pixel-rate divider feeding horizontal/vertical scan counters,
// with sync, blanking and strobe outputs decoded combinationally from the counters.
module vga_scan_timing #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CLK_DIV   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [9:0] Q_X,
  output logic [9:0] Q_Y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       pix_tick,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt;
  logic             div_last;
  logic             x_last;
  logic             y_last;

  assign div_last = (div_cnt == DIV_LAST);
  assign x_last   = (Q_X == H_LAST);
  assign y_last   = (Q_Y == V_LAST);

  // With CLK_DIV=1 the divider is a constant zero and div_last is always true.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
      Q_X     <= '0;
      Q_Y     <= '0;
    end else if (en) begin
      div_cnt <= div_last ? '0 : div_cnt + 1'b1;
      if (div_last) begin
        if (x_last) begin
          Q_X <= '0;
          Q_Y <= y_last ? '0 : Q_Y + 1'b1;
        end else begin
          Q_X <= Q_X + 1'b1;
        end
      end
    end
  end

  // Decodes are gated by rst_n so a reset mid-pulse drops sync immediately.
  always_comb begin
    pix_tick    = rst_n && en && div_last;
    line_start  = pix_tick && (Q_X == '0);
    frame_start = line_start && (Q_Y == '0);
    hsync       = !(rst_n && (Q_X >= HS_START) && (Q_X < HS_END));
    vsync       = !(rst_n && (Q_Y >= VS_START) && (Q_Y < VS_END));
    video_on    = rst_n && (Q_X < H_VIS) && (Q_Y < V_VIS);
  end

endmodule

// File: tb/tb_vga_scan_timing.sv
// Bench for vga_scan_timing: one default instance plus two reduced-geometry
// instances (CLK_DIV=1 and 3), all compared each cycle against a pixel-count model.
module tb_vga_scan_timing;

  logic clk = 1'b0;
  logic rst_n, en;
  always #5 clk = ~clk;

  logic [9:0] a_x, a_y, b_x, b_y, c_x, c_y;
  logic a_hs, a_vs, a_vid, a_tick, a_ls, a_fs;
  logic b_hs, b_vs, b_vid, b_tick, b_ls, b_fs;
  logic c_hs, c_vs, c_vid, c_tick, c_ls, c_fs;

  vga_scan_timing dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .Q_X(a_x), .Q_Y(a_y),
    .hsync(a_hs), .vsync(a_vs), .video_on(a_vid), .pix_tick(a_tick),
    .line_start(a_ls), .frame_start(a_fs));

  vga_scan_timing #(.H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .CLK_DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .Q_X(b_x), .Q_Y(b_y),
    .hsync(b_hs), .vsync(b_vs), .video_on(b_vid), .pix_tick(b_tick),
    .line_start(b_ls), .frame_start(b_fs));

  vga_scan_timing #(.H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .CLK_DIV(3)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .Q_X(c_x), .Q_Y(c_y),
    .hsync(c_hs), .vsync(c_vs), .video_on(c_vid), .pix_tick(c_tick),
    .line_start(c_ls), .frame_start(c_fs));

  typedef struct {
    int x, y;
    bit hs, vs, vid, tick, ls, fs;
  } exp_t;

  int    n_cmp = 0;
  int    n_err = 0;
  longint cyc = 0;  // enabled, out-of-reset clock cycles since the last reset

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pixel index = completed ticks mod frame size; coordinates follow by div/mod.
  function automatic exp_t ref_scan(int hv, int hf, int hsw, int hb, int vv, int vf, int vsw,
                                    int vb, int dv, longint c, bit r, bit e);
    exp_t   res;
    int     ht = hv + hf + hsw + hb;
    int     vt = vv + vf + vsw + vb;
    longint p  = (c / dv) % (ht * vt);
    res.x    = int'(p % ht);
    res.y    = int'(p / ht);
    res.tick = r && e && ((c % dv) == dv - 1);
    res.ls   = res.tick && res.x == 0;
    res.fs   = res.ls && res.y == 0;
    res.hs   = !(r && res.x >= hv + hf && res.x < hv + hf + hsw);
    res.vs   = !(r && res.y >= vv + vf && res.y < vv + vf + vsw);
    res.vid  = r && res.x < hv && res.y < vv;
    return res;
  endfunction

  task automatic cmp_dut(input string nm, input exp_t e, input logic [9:0] x, input logic [9:0] y,
                         input logic hs, input logic vs, input logic vid, input logic tk,
                         input logic ls, input logic fs);
    check({nm, ".x"}, 32'(x), 32'(e.x));
    check({nm, ".y"}, 32'(y), 32'(e.y));
    check({nm, ".hsync"}, 32'(hs), 32'(e.hs));
    check({nm, ".vsync"}, 32'(vs), 32'(e.vs));
    check({nm, ".video_on"}, 32'(vid), 32'(e.vid));
    check({nm, ".pix_tick"}, 32'(tk), 32'(e.tick));
    check({nm, ".line_start"}, 32'(ls), 32'(e.ls));
    check({nm, ".frame_start"}, 32'(fs), 32'(e.fs));
  endtask

  task automatic drive(input bit r, input bit e, input bit chk = 1'b1);
    @(negedge clk);
    rst_n = r;
    en    = e;
    #1;
    if (chk) begin
      cmp_dut("a", ref_scan(640, 16, 96, 48, 480, 10, 2, 33, 2, cyc, r, e),
              a_x, a_y, a_hs, a_vs, a_vid, a_tick, a_ls, a_fs);
      cmp_dut("b", ref_scan(8, 2, 3, 3, 6, 1, 2, 2, 1, cyc, r, e),
              b_x, b_y, b_hs, b_vs, b_vid, b_tick, b_ls, b_fs);
      cmp_dut("c", ref_scan(8, 2, 3, 3, 6, 1, 2, 2, 3, cyc, r, e),
              c_x, c_y, c_hs, c_vs, c_vid, c_tick, c_ls, c_fs);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    if (!rst_n) cyc = 0;
    else if (en) cyc++;
  endtask

  task automatic step(input bit r, input bit e);
    drive(r, e);
    adv();
  endtask

  // First four cycles after reset release on the default instance.
  task automatic scn_release(input string tag);
    drive(1, 1); check({tag, ".tick0"}, 32'(a_tick), 0); adv();
    drive(1, 1); check({tag, ".tick1"}, 32'(a_tick), 1);
                 check({tag, ".fs1"}, 32'(a_fs), 1); adv();
    drive(1, 1); check({tag, ".x2"}, 32'(a_x), 1);
                 check({tag, ".tick2"}, 32'(a_tick), 0); adv();
    drive(1, 1); check({tag, ".fs3"}, 32'(a_fs), 0);
                 check({tag, ".tick3"}, 32'(a_tick), 1); adv();
  endtask

  initial begin
    int hs_ticks, vid_ticks, last_ls, ls_period;
    int last_bfs, bfs_period, last_cfs, cfs_period, b_vs_low;
    bit reached;

    rst_n = 1'b0;
    en    = 1'b0;
    drive(0, 0, 0); adv();
    step(0, 1);
    step(0, 1);

    // Release, then one full default line plus one frame of each small instance.
    scn_release("s1");
    hs_ticks = 0; vid_ticks = 0; last_ls = 1; ls_period = 0;
    last_bfs = 0; bfs_period = 0; last_cfs = 2; cfs_period = 0; b_vs_low = 0;
    for (int k = 4; k < 1602; k++) begin
      drive(1, 1);
      if (k < 1600 && a_tick && !a_hs) hs_ticks++;
      if (k < 1600 && a_tick && a_vid) vid_ticks++;
      if (k > 1 && a_ls) begin ls_period = k - last_ls; last_ls = k; end
      if (b_fs) begin bfs_period = k - last_bfs; last_bfs = k; end
      if (k > 2 && c_fs) begin cfs_period = k - last_cfs; last_cfs = k; end
      if (k >= 176 && k < 352 && !b_vs) b_vs_low++;
      adv();
    end
    // The hsync window (x=656..751) never overlaps the four release cycles.
    check("line.hsync_ticks", 32'(hs_ticks), 96);
    check("line.video_ticks", 32'(vid_ticks + 2), 640);
    check("line.ls_period", 32'(ls_period), 1600);
    check("b.frame_period", 32'(bfs_period), 176);
    check("c.frame_period", 32'(cfs_period), 528);
    check("b.vsync_low_cycles", 32'(b_vs_low), 32);

    // Enable gap of 37 cycles at Q_X=100.
    reached = 0;
    for (int k = 0; k < 2000 && !reached; k++) begin
      if ((cyc / 2) % 800 == 100) reached = 1;
      else step(1, 1);
    end
    check("gap.reach", 32'(reached), 1);
    for (int k = 0; k < 37; k++) begin
      drive(1, 0);
      check("gap.hold_x", 32'(a_x), 100);
      check("gap.no_tick", 32'(a_tick | a_ls | a_fs), 0);
      adv();
    end
    drive(1, 1); check("gap.resume_div0", 32'(a_tick), 0); adv();
    drive(1, 1); check("gap.resume_tick", 32'(a_tick), 1); adv();
    drive(1, 1); check("gap.resume_x", 32'(a_x), 101); adv();

    // Randomized enable pattern with occasional resets.
    for (int k = 0; k < 3000; k++)
      step($urandom_range(0, 599) != 0, $urandom_range(0, 3) != 0);

    // Reset mid-frame while the small instance is inside its hsync pulse.
    reached = 0;
    for (int k = 0; k < 400 && !reached; k++) begin
      if (cyc % 176 == 75) reached = 1;
      else step(1, 1);
    end
    check("rst.reach", 32'(reached), 1);
    drive(1, 1);
    check("rst.b_x_before", 32'(b_x), 11);
    check("rst.b_hs_before", 32'(b_hs), 0);
    adv();
    drive(0, 1);
    check("rst.b_hs_during", 32'(b_hs), 1);
    check("rst.b_vid_during", 32'(b_vid), 0);
    adv();
    drive(0, 1);
    check("rst.b_x_after", 32'(b_x), 0);
    check("rst.b_y_after", 32'(b_y), 0);
    adv();
    scn_release("s1b");
    for (int k = 0; k < 500; k++) step(1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_scan_timing.md
VGA_SCAN_TIMING -- requirements
Module: vga_scan_timing

Interface
REQ-001 The block SHALL expose these parameters:
- H_VISIBLE, 640, active pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, horizontal sync width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_VISIBLE, 480, active lines per frame.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BP, 33, vertical back porch in lines.
- CLK_DIV, 2, clk cycles per pixel (>=1).

REQ-002 The block SHALL expose these ports, clock and reset first:
- clk  in  1  single system clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- en  in  1  scan enable; 0 freezes all scan state.
- Q_X  out  10  current horizontal pixel coordinate (0..H_TOTAL-1).
- Q_Y  out  10  current vertical line coordinate (0..V_TOTAL-1).
- hsync  out  1  horizontal sync, active low.
- vsync  out  1  vertical sync, active low.
- video_on  out  1  high while (Q_X,Q_Y) lies in the visible area.
- pix_tick  out  1  one-clk pixel strobe; coordinates advance after it.
- line_start  out  1  one-clk pulse at pixel (0,Q_Y).
- frame_start  out  1  one-clk pulse at pixel (0,0).

REQ-003 Q_X and Q_Y SHALL use the same coordinate convention consumed by the glyph and sprite draw blocks: (0,0) is the top-left visible pixel.

Function
REQ-004 H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800) and V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525); both SHALL fit in 10 bits.
REQ-005 A divider counter SHALL run 0..CLK_DIV-1 while en=1; pix_tick=1 exactly when en=1 and divider==CLK_DIV-1, after which the divider wraps to 0.
REQ-006 When CLK_DIV=1, pix_tick SHALL equal en.
REQ-007 On each pix_tick, Q_X SHALL increment; at Q_X==H_TOTAL-1 it SHALL wrap to 0 and Q_Y SHALL increment.
REQ-008 On the pix_tick where Q_X==H_TOTAL-1 and Q_Y==V_TOTAL-1, both SHALL wrap to 0 on the same edge.
REQ-009 Q_X and Q_Y SHALL be registered and change only on the clk edge that ends a pix_tick cycle.
REQ-010 hsync SHALL be 0 exactly while H_VISIBLE+H_FP <= Q_X < H_VISIBLE+H_FP+H_SYNC (656..751).
REQ-011 vsync SHALL be 0 exactly while V_VISIBLE+V_FP <= Q_Y < V_VISIBLE+V_FP+V_SYNC (490..491).
REQ-012 video_on SHALL be (Q_X<H_VISIBLE && Q_Y<V_VISIBLE) && rst_n.
REQ-013 hsync, vsync and video_on SHALL be combinational decodes of the registered counters, aligned in the same cycle as Q_X/Q_Y.
REQ-014 line_start SHALL be pix_tick && Q_X==0; frame_start SHALL be pix_tick && Q_X==0 && Q_Y==0.
REQ-015 With en=0, the divider, Q_X and Q_Y SHALL hold, and pix_tick, line_start and frame_start SHALL be 0; sync and video_on SHALL keep decoding the held counters.
REQ-016 When en deasserts mid-line and later reasserts, the scan SHALL resume from the held divider value with no pixel skipped or repeated.

Reset
REQ-017 While rst_n=0 at a clk edge, divider, Q_X and Q_Y SHALL load 0, overriding en and any pending wrap.
REQ-018 During reset the outputs SHALL be hsync=1, vsync=1, video_on=0, pix_tick=0, line_start=0, frame_start=0.
REQ-019 After rst_n rises with en=1, the first pix_tick SHALL occur CLK_DIV-1 cycles later, and that tick SHALL assert frame_start (pixel 0,0).
REQ-020 A reset asserted mid-frame SHALL abandon the frame; no partial sync pulse SHALL be generated after release.

Verification
REQ-021 The bench SHALL cover these directed scenarios with default parameters:
- Reset release, en=1: pix_tick on cycles 1,3,5,...; frame_start only at cycle 1; Q_X=1 at cycle 2.
- Full line: hsync low for exactly 96 pix_ticks starting at Q_X=656; line_start period of 1600 clk; video_on high for 640 ticks per visible line.
- Full frame: vsync low for Q_Y=490..491 (2 lines = 3200 clk); frame_start period of 840000 clk; Q_Y wraps 524->0 together with Q_X 799->0.
- Enable gap: en=0 for 37 cycles at Q_X=100 -> Q_X, Q_Y and the divider hold; no strobes; resume continues at 101 with correct spacing.
- Reset mid-frame at Q_Y=300, Q_X=700 -> next edge gives Q_X=Q_Y=0, hsync=1, video_on=0; scenario 1 behaviour repeats after release.
- CLK_DIV=1 instance: pix_tick=en every cycle; frame period of 420000 clk.
